// File: rtl/mips_pkg.sv
// mips_pkg: shared requester roles and constants for the writeback path
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_AW = 5;
  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_LOAD = 2'd1;
  localparam logic [1:0] REQ_FP = 2'd2;
  localparam logic [1:0] REQ_JAL = 2'd3;
  localparam int LINK_REG = 31;
  localparam int PC_INC = 4;
endpackage

// File: rtl/mips_rr_pick.sv
// mips_rr_pick: combinational 4-way round-robin picker starting at i_ptr
module mips_rr_pick (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_gnt,
  output logic [1:0] o_win
);
  logic [1:0] w_off;
  // distance from the pointer to the first requester in search order
  always_comb begin
    w_off = '0;
    for (int k = 3; k >= 0; k--) if (i_req[2'(k) + i_ptr]) w_off = 2'(k);
  end
  assign o_win = i_ptr + w_off;
  assign o_gnt = |i_req ? 4'b0001 << o_win : 4'b0000;
endmodule

// File: rtl/mips_wb_arbiter.sv
// mips_wb_arbiter: round-robin owner of the register file's single write port
module mips_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW = DEF_AW,
  parameter int NREQ = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              STALL,
  input  logic [NREQ-1:0]   REQ,
  input  logic [4*AW-1:0]   REQ_IDX,
  input  logic [4*DATA_W-1:0] REQ_DATA,
  input  logic [DATA_W-1:0] PC,
  output logic [NREQ-1:0]   GNT,
  output logic              WB_WE,
  output logic              WB_FP,
  output logic [AW-1:0]     WB_IDX,
  output logic [DATA_W-1:0] WB_DATA,
  output logic [1:0]        WB_SRC
);
  logic [1:0] r_ptr, r_src;
  logic r_we, r_fp;
  logic [AW-1:0] r_idx;
  logic [DATA_W-1:0] r_data;
  logic [3:0] w_pick;
  logic [1:0] w_win;
  logic w_go, w_fp, w_jal, w_we;
  logic [AW-1:0] w_idx;
  logic [DATA_W-1:0] w_data;

  mips_rr_pick u_pick (.i_req(REQ), .i_ptr(r_ptr), .o_gnt(w_pick), .o_win(w_win));

  assign GNT = (RST_N && !STALL) ? w_pick : '0;
  assign w_go = |GNT;
  assign w_fp = w_win == REQ_FP;
  assign w_jal = w_win == REQ_JAL;
  assign w_idx = w_jal ? AW'(LINK_REG) : REQ_IDX[w_win*AW +: AW];
  assign w_data = w_jal ? PC + DATA_W'(PC_INC) : REQ_DATA[w_win*DATA_W +: DATA_W];
  // writes to int register 0 are consumed but never enabled
  assign w_we = w_fp || (w_idx != '0);

  // pointer and write-port register; stall freezes everything, idle drops enable only
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr <= '0;
      r_we <= 1'b0;
      r_fp <= 1'b0;
      r_idx <= '0;
      r_data <= '0;
      r_src <= '0;
    end else if (!STALL) begin
      if (w_go) begin
        r_ptr <= w_win + 2'd1;
        r_we <= w_we;
        r_fp <= w_fp;
        r_idx <= w_idx;
        r_data <= w_data;
        r_src <= w_win;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign WB_WE = r_we;
  assign WB_FP = r_fp;
  assign WB_IDX = r_idx;
  assign WB_DATA = r_data;
  assign WB_SRC = r_src;
endmodule

// File: tb/tb_mips_wb_arbiter.sv
// tb_mips_wb_arbiter: directed literal checks plus randomized run against a behavioural model
module tb_mips_wb_arbiter;
  logic CLK = 1'b0;
  logic RST_N, STALL;
  logic [3:0] REQ, GNT;
  logic [19:0] REQ_IDX;
  logic [127:0] REQ_DATA;
  logic [31:0] PC, WB_DATA;
  logic WB_WE, WB_FP;
  logic [4:0] WB_IDX;
  logic [1:0] WB_SRC;
  int n_pass = 0, n_tot = 0;

  mips_wb_arbiter dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .REQ(REQ), .REQ_IDX(REQ_IDX),
    .REQ_DATA(REQ_DATA), .PC(PC), .GNT(GNT), .WB_WE(WB_WE), .WB_FP(WB_FP),
    .WB_IDX(WB_IDX), .WB_DATA(WB_DATA), .WB_SRC(WB_SRC)
  );

  always #5 CLK = ~CLK;

  // model state: priority start and the write currently on the port
  int m_ptr;
  logic m_we, m_fp;
  logic [4:0] m_idx;
  logic [31:0] m_data;
  logic [1:0] m_src;

  function automatic int winner(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    int w;
    w = winner(REQ, m_ptr);
    if (!RST_N || STALL || w < 0) return 4'b0000;
    return 4'b0001 << w;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge CLK or negedge RST_N) begin
    int w;
    if (!RST_N) begin
      m_ptr <= 0; m_we <= 0; m_fp <= 0; m_idx <= 0; m_data <= 0; m_src <= 0;
    end else if (!STALL) begin
      w = winner(REQ, m_ptr);
      if (w >= 0) begin
        logic [4:0] ix;
        ix = (w == 3) ? 5'd31 : REQ_IDX[w*5 +: 5];
        m_ptr <= (w + 1) % 4;
        m_src <= 2'(w);
        m_fp <= (w == 2);
        m_idx <= ix;
        m_data <= (w == 3) ? PC + 32'd4 : REQ_DATA[w*32 +: 32];
        m_we <= (w == 2) || (ix != 0);
      end else m_we <= 0;
    end
  end

  always @(negedge CLK) begin
    chk("gnt", 32'(GNT), 32'(exp_gnt()));
    chk("we", 32'(WB_WE), 32'(m_we));
    chk("fp", 32'(WB_FP), 32'(m_fp));
    chk("idx", 32'(WB_IDX), 32'(m_idx));
    chk("data", WB_DATA, m_data);
    chk("src", 32'(WB_SRC), 32'(m_src));
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 0; STALL = 0; REQ = 0; REQ_IDX = 0; REQ_DATA = 0; PC = 0;
    step(); step();
    @(negedge CLK);
    chk("rst_we", 32'(WB_WE), 0);
    chk("rst_gnt", 32'(GNT), 0);
    step();
    RST_N = 1; REQ = 4'b0001; REQ_IDX[4:0] = 5; REQ_DATA[31:0] = 32'hDEADBEEF;
    @(negedge CLK); chk("t1_gnt", 32'(GNT), 1);
    step(); REQ = 0;
    @(negedge CLK);
    chk("t1_we", 32'(WB_WE), 1); chk("t1_fp", 32'(WB_FP), 0);
    chk("t1_idx", 32'(WB_IDX), 5); chk("t1_data", WB_DATA, 32'hDEADBEEF);
    chk("t1_src", 32'(WB_SRC), 0);
    step(); REQ = 4'b1000; PC = 32'h00400010;
    @(negedge CLK); chk("ptr1_gnt", 32'(GNT), 8);
    step(); REQ = 4'b1111; REQ_IDX = 20'h0_0C41;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); chk("rr_gnt", 32'(GNT), 32'(1) << i);
      step();
    end
    REQ = 0;
    @(negedge CLK);
    chk("jal_idx", 32'(WB_IDX), 31); chk("jal_data", WB_DATA, 32'h00400014);
    step(); REQ = 4'b0001; REQ_IDX[4:0] = 0; REQ_DATA[31:0] = 32'h1234;
    @(negedge CLK); chk("r0_gnt", 32'(GNT), 1);
    step(); REQ = 4'b0100; REQ_IDX[14:10] = 0;
    @(negedge CLK); chk("r0_we", 32'(WB_WE), 0); chk("fp0_gnt", 32'(GNT), 4);
    step(); STALL = 1; REQ = 4'b0110; REQ_IDX[9:5] = 7; REQ_DATA[63:32] = 32'hCAFE0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_gnt", 32'(GNT), 0); chk("stall_we", 32'(WB_WE), 1);
      chk("stall_fp", 32'(WB_FP), 1); chk("stall_idx", 32'(WB_IDX), 0);
      step();
    end
    STALL = 0;
    @(negedge CLK); chk("unstall_gnt", 32'(GNT), 2);
    step(); REQ = 0;
    @(negedge CLK); chk("l_we", 32'(WB_WE), 1); chk("l_data", WB_DATA, 32'hCAFE0001);
    #2 RST_N = 0;
    #1;
    chk("arst_we", 32'(WB_WE), 0); chk("arst_data", WB_DATA, 0);
    chk("arst_idx", 32'(WB_IDX), 0); chk("arst_gnt", 32'(GNT), 0);
    step(); RST_N = 1; REQ = 4'b1111;
    @(negedge CLK); chk("post_rst_gnt", 32'(GNT), 1);
    step(); REQ = 4'b1000; PC = 32'hFFFFFFFC;
    @(negedge CLK); chk("wrap_gnt", 32'(GNT), 8);
    step(); REQ = 0;
    @(negedge CLK);
    chk("wrap_data", WB_DATA, 0); chk("wrap_idx", 32'(WB_IDX), 31); chk("wrap_we", 32'(WB_WE), 1);
    step();
    for (int c = 0; c < 3000; c++) begin
      REQ = 4'($urandom);
      for (int s = 0; s < 4; s++) begin
        REQ_IDX[s*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        REQ_DATA[s*32 +: 32] = $urandom;
      end
      PC = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      STALL = $urandom_range(0, 4) == 0;
      RST_N = $urandom_range(0, 199) != 0;
      step();
    end
    RST_N = 1; STALL = 0; REQ = 0;
    step();
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mips_wb_arbiter.md
# mips_wb_arbiter

Round-robin arbiter for the register file's single write port. It shares that port between four writeback requesters: integer ALU, integer load, FP unit and JAL link. Each requester uses a valid/grant handshake. The arbiter registers the winning write and drives the register file's write-enable, FP-select, destination and data inputs, so two producers never collide in one cycle.

## Interface
- DATA_W, 32, write data width
- AW, 5, register index width (32 registers per bank)
- NREQ, 4, number of requesters; fixed at 4, requester index defines its role
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low
- STALL  in  1  pipeline freeze; no grants, output and pointer held
- REQ  in  4  request valid; bit0 ALU (int), bit1 LOAD (int), bit2 FP (float bank), bit3 JAL (int, link)
- REQ_IDX  in  4*AW  destination index per requester, slice i = [i*AW +: AW]; slice 3 ignored
- REQ_DATA  in  4*DATA_W  write data per requester; slice 3 ignored
- PC  in  DATA_W  PC of the JAL instruction, valid while REQ[3]
- GNT  out  4  one-hot grant, combinational, same cycle as accepted REQ
- WB_WE  out  1  register-file write enable (RegWrite)
- WB_FP  out  1  bank select (FPinst): 1 = float bank
- WB_IDX  out  AW  destination register (WriteReg / Fd)
- WB_DATA  out  DATA_W  write data
- WB_SRC  out  2  index of requester whose write is on the port (debug/verification)

## Operation
- Round-robin pointer PTR (2 bits) names the highest-priority requester. The search order is PTR, PTR+1, …, wrapping mod 4.
- Per cycle with STALL=0: the first set REQ bit in search order gets GNT. Any other set bits are refused.
- At most one GNT bit is high. GNT is 0 when REQ=0 or STALL=1.
- On grant to i, PTR ← (i+1) mod 4. With no grant, PTR is unchanged.
- Requesters hold REQ, REQ_IDX and REQ_DATA stable until the cycle their GNT is high. The payload is sampled in that cycle. A requester that drops REQ without a grant loses its write; this is legal but not retried.
- Payload formation on grant:
  - Requesters 0/1: WB_FP=0, IDX/DATA from their slice.
  - Requester 2: WB_FP=1.
  - Requester 3: WB_FP=0, WB_IDX=31, WB_DATA=PC+4 (mod 2^32).
- Register-0 rule: an int-bank write (WB_FP=0) with index 0 is granted and consumed, but WB_WE stays 0. The write is dropped and PTR still advances.
- FP index 0 is a normal writable register; WB_WE=1.
- STALL=1: no grants; WB_* outputs and PTR hold their current values.
  - If WB_WE was 1 when STALL rose, it stays 1 for the stall duration. The register file rewrites the same value, which is idempotent.
- No grant and STALL=0: WB_WE ← 0. WB_FP/WB_IDX/WB_DATA/WB_SRC hold their last values.
- Two requesters targeting the same register in one cycle are serialized by arbitration order. The later grant wins in the register file.

## Timing
- Grant latency 0 cycles: GNT is combinational from REQ, PTR and STALL.
- Write latency 1 cycle: the payload granted in cycle n appears on WB_* in cycle n+1. The register file commits at the edge ending cycle n+1.
- Throughput is 1 write per cycle. Each requester is guaranteed a grant within 4 cycles of asserting REQ, provided STALL=0.
- Reset (RST_N=0, async): PTR=0, WB_WE=0, WB_FP=0, WB_IDX=0, WB_DATA=0, WB_SRC=0.
  - GNT=0 while RST_N=0.
  - Reset mid-write aborts the registered write; WB_WE drops immediately.
- First cycle after reset release: requester 0 has top priority.

## Structure
- Shared package mips_pkg: requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_FP=2, REQ_JAL=3), LINK_REG=31, PC_INC=4, DATA_W/AW defaults.
- One natural sub-module: mips_rr_pick. It is a combinational 4-way round-robin priority picker taking REQ and PTR, and producing one-hot GNT and a 2-bit winner index. This is reusable for a later memory-port arbiter.
- The top level holds PTR, the output register, payload mux, PC+4 adder and register-0 suppression.

## Test plan
- Reset, then REQ=4'b0001, IDX0=5, DATA0=0xDEADBEEF → GNT=0001; next cycle WB_WE=1, WB_FP=0, WB_IDX=5, WB_DATA=0xDEADBEEF, WB_SRC=0; PTR=1.
- REQ=4'b1111 held 4 cycles with PTR=0 → GNT sequence 0001, 0010, 0100, 1000. The JAL write shows WB_IDX=31 and WB_DATA=PC+4 (PC=0x00400010 → 0x00400014).
- REQ[0] with IDX0=0, DATA0=0x1234 → GNT=0001; next cycle WB_WE=0 and PTR=1. The same request on REQ[2] with IDX2=0 → WB_WE=1, WB_FP=1, WB_IDX=0.
- Write in flight (WB_WE=1), then STALL=1 for 3 cycles with REQ=4'b0110 → GNT=0 throughout; WB_* and PTR unchanged. After STALL falls, GNT=0010.
- Assert RST_N=0 asynchronously mid-cycle while WB_WE=1 → WB_WE and all outputs go to 0 before the next edge. After release, PTR=0.
- JAL with PC=0xFFFFFFFC → WB_DATA=0x00000000 (wrap).
